// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } dmem_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Stores have no unsigned variants; loads accept all five RV32I widths.
  function automatic logic f3_legal(input logic we, input logic [2:0] funct3);
    if (we) begin
      return funct3 inside {F3_B, F3_H, F3_W};
    end
    return funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// Byte-lane steering: store enables/replication, load shift/extension, misalign detect.
module dmem_lsu_align
  import dmem_pkg::*;
(
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);

  logic [31:0] shifted;

  // Store lane enables, replicated store data and alignment check by access width.
  always_comb begin
    be_o       = '0;
    wdata_o    = wdata_i;
    misalign_o = 1'b0;
    case (funct3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << off_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_o       = 4'b0011 << off_i;
        wdata_o    = {2{wdata_i[15:0]}};
        misalign_o = off_i[0];
      end
      default: begin
        be_o       = 4'b1111;
        misalign_o = (off_i != 2'b00);
      end
    endcase
  end

  // Right-justify the addressed bytes, then sign- or zero-extend.
  always_comb begin
    shifted = rword_i >> {off_i, 3'b000};
    case (funct3_i)
      F3_B:    rdata_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   rdata_o = {24'h0, shifted[7:0]};
      F3_H:    rdata_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   rdata_o = {16'h0, shifted[15:0]};
      default: rdata_o = shifted;
    endcase
  end

endmodule

// File: rtl/dmem_resp.sv
// Fixed-latency scratchpad responder for the MEM stage with stall/ready handshake.
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_W   = 10,
  parameter int unsigned LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_2000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] rdata_o,
  output logic        ready_o,
  output logic        err_o,
  output logic        stall_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_W;
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  dmem_state_e         state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [31:0]         mem_q [DEPTH];
  logic [DEPTH_W-1:0]  word_idx;
  logic [31:0]         rword;
  logic [3:0]          be;
  logic [3:0]          mem_be;
  logic [31:0]         st_data;
  logic [31:0]         ld_data;
  logic                misalign;
  logic                in_range;
  logic                legal;

  assign word_idx = addr_i[DEPTH_W+1:2];
  assign rword    = mem_q[word_idx];
  assign in_range = (addr_i[31:DEPTH_W+2] == BASE_ADDR[31:DEPTH_W+2]);
  assign legal    = in_range & ~misalign & f3_legal(we_i, funct3_i);

  dmem_lsu_align u_align (
    .off_i      (addr_i[1:0]),
    .funct3_i   (funct3_i),
    .wdata_i    (wdata_i),
    .rword_i    (rword),
    .be_o       (be),
    .wdata_o    (st_data),
    .rdata_o    (ld_data),
    .misalign_o (misalign)
  );

  // Next-state, latency countdown, load capture and store lane selection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_be  = '0;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          if (legal) begin
            state_d = WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
            err_d   = 1'b0;
          end else begin
            state_d = DONE;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end
      WAIT: begin
        if (!valid_i) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = DONE;
          err_d   = 1'b0;
          if (we_i) begin
            mem_be = be;
          end else begin
            rdata_d = ld_data;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and result registers; reset abandons any in-flight request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Scratchpad byte-lane writes; contents survive reset, but a reset edge blocks the write.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (mem_be[b]) begin
          mem_q[word_idx][8*b +: 8] <= st_data[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = rdata_q;
  assign ready_o = (state_q == DONE);
  assign err_o   = (state_q == DONE) & err_q;
  assign stall_o = valid_i & (state_q != DONE) & ~rst_i;

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp with a byte-level memory model and per-cycle output checks.
module tb_dmem_resp;
  import dmem_pkg::*;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] addr_i = 32'h0;
  logic [31:0] wdata_i = 32'h0;
  logic [2:0]  funct3_i = 3'b0;
  logic [31:0] rdata_o;
  logic        ready_o;
  logic        err_o;
  logic        stall_o;

  dmem_resp #(
    .DEPTH_W   (10),
    .LATENCY   (LAT),
    .BASE_ADDR (32'h0000_2000)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .we_i     (we_i),
    .addr_i   (addr_i),
    .wdata_i  (wdata_i),
    .funct3_i (funct3_i),
    .rdata_o  (rdata_o),
    .ready_o  (ready_o),
    .err_o    (err_o),
    .stall_o  (stall_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  bit          chk_en = 1'b0;
  logic        exp_stall, exp_ready, exp_err;
  logic [31:0] exp_rdata;
  logic [31:0] hold = 32'h0;

  logic [7:0] mbytes [logic [31:0]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int mdl_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return 1;
      F3_H, F3_HU: return 2;
      F3_W:        return 4;
      default:     return 0;
    endcase
  endfunction

  function automatic bit mdl_legal(input logic we, input logic [31:0] a, input logic [2:0] f3);
    int sz;
    sz = mdl_size(f3);
    if ((a >> 12) != 32'h2) return 1'b0;
    if (sz == 0) return 1'b0;
    if (we && (f3 == F3_BU || f3 == F3_HU)) return 1'b0;
    if ((a % sz) != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] mdl_load(input logic [31:0] a, input logic [2:0] f3);
    logic [31:0] v;
    v = 32'h0;
    for (int i = 0; i < mdl_size(f3); i++) v = v | (32'(mbytes[a + i]) << (8 * i));
    if (f3 == F3_B && v >= 32'd128) v = v - 32'd256;
    if (f3 == F3_H && v >= 32'd32768) v = v - 32'd65536;
    return v;
  endfunction

  task automatic mdl_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
    for (int i = 0; i < mdl_size(f3); i++) mbytes[a + i] = d[8*i +: 8];
  endtask

  // Per-cycle comparison of every output against the expectations set by the driver.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", {31'h0, stall_o}, {31'h0, exp_stall});
      chk("ready", {31'h0, ready_o}, {31'h0, exp_ready});
      chk("err", {31'h0, err_o}, {31'h0, exp_err});
      chk("rdata", rdata_o, exp_rdata);
    end
  end

  task automatic step(input logic v, input logic r, input logic es, input logic er, input logic ee);
    @(posedge clk);
    #1;
    valid_i   = v;
    rst_i     = r;
    exp_stall = es;
    exp_ready = er;
    exp_err   = ee;
    exp_rdata = hold;
  endtask

  // abort: 0 = run to completion, 1 = drop valid in first WAIT cycle, 2 = reset in first WAIT cycle
  task automatic txn(input logic we, input logic [31:0] a, input logic [31:0] d,
                     input logic [2:0] f3, input int abort);
    bit lg;
    lg = mdl_legal(we, a, f3);
    @(posedge clk);
    #1;
    we_i = we; addr_i = a; wdata_i = d; funct3_i = f3;
    valid_i = 1'b1; rst_i = 1'b0;
    exp_stall = 1'b1; exp_ready = 1'b0; exp_err = 1'b0; exp_rdata = hold;
    if (!lg) begin
      hold = 32'h0;
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      return;
    end
    for (int k = 1; k <= LAT; k++) begin
      if (abort == 1 && k == 1) begin
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        return;
      end
      if (abort == 2 && k == 1) begin
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        hold = 32'h0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        return;
      end
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    if (we) mdl_store(a, f3, d);
    else    hold = mdl_load(a, f3);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a request present: must be ignored and stall held low.
    valid_i = 1'b1; we_i = 1'b0; addr_i = 32'h2000; funct3_i = F3_W;
    @(posedge clk);
    #1;
    exp_stall = 1'b0; exp_ready = 1'b0; exp_err = 1'b0; exp_rdata = 32'h0;
    chk_en = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    txn(1'b1, 32'h2000, 32'hA5A5_1234, F3_W, 0);
    txn(1'b1, 32'h2008, 32'h0BAD_F00D, F3_W, 0);
    txn(1'b1, 32'h200C, 32'hCAFE_0001, F3_W, 0);

    txn(1'b1, 32'h2004, 32'hDEAD_BEEF, F3_W, 0);
    txn(1'b0, 32'h2004, 32'h0, F3_W, 0);
    chk("lit_lw_2004", rdata_o, 32'hDEAD_BEEF);

    txn(1'b1, 32'h2005, 32'h1234_5680, F3_B, 0);
    txn(1'b0, 32'h2005, 32'h0, F3_B, 0);
    chk("lit_lb", rdata_o, 32'hFFFF_FF80);
    txn(1'b0, 32'h2005, 32'h0, F3_BU, 0);
    chk("lit_lbu", rdata_o, 32'h0000_0080);
    txn(1'b0, 32'h2004, 32'h0, F3_W, 0);
    chk("lit_lw_merge", rdata_o, 32'hDEAD_80EF);
    txn(1'b0, 32'h2006, 32'h0, F3_H, 0);
    chk("lit_lh", rdata_o, 32'hFFFF_DEAD);
    txn(1'b0, 32'h2006, 32'h0, F3_HU, 0);
    chk("lit_lhu", rdata_o, 32'h0000_DEAD);

    txn(1'b1, 32'h2003, 32'h0000_5555, F3_H, 0);
    chk("lit_err_rdata", rdata_o, 32'h0);
    txn(1'b0, 32'h2000, 32'h0, F3_W, 0);
    chk("lit_sh_blocked", rdata_o, 32'hA5A5_1234);

    txn(1'b0, 32'h3000, 32'h0, F3_W, 0);
    chk("lit_oor", rdata_o, 32'h0);
    txn(1'b0, 32'h2004, 32'h0, F3_W, 0);
    txn(1'b0, 32'h2000, 32'h0, 3'b011, 0);
    chk("lit_bad_f3", rdata_o, 32'h0);
    txn(1'b1, 32'h2000, 32'hFFFF_FFFF, F3_BU, 0);
    txn(1'b0, 32'h2002, 32'h0, F3_W, 0);

    txn(1'b1, 32'h2002, 32'h7777_BEEF, F3_H, 0);
    txn(1'b0, 32'h2000, 32'h0, F3_W, 0);
    chk("lit_sh_hi", rdata_o, 32'hBEEF_1234);

    txn(1'b1, 32'h2008, 32'h1234_5678, F3_W, 1);
    txn(1'b0, 32'h2008, 32'h0, F3_W, 0);
    chk("lit_flush", rdata_o, 32'h0BAD_F00D);

    txn(1'b1, 32'h200C, 32'h1111_2222, F3_W, 2);
    txn(1'b0, 32'h200C, 32'h0, F3_W, 0);
    chk("lit_rst_wait", rdata_o, 32'hCAFE_0001);

    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
